apb4_mem_slave: RTL and testbench

//   APB4 memory-mapped slave with a byte-addressed register-file memory. Adds PSTRB byte-lane writes,

---
 rtl/apb_mem_pkg.sv | 14 +
 rtl/apb_strb_ram.sv | 32 +++
 rtl/apb4_mem_slave.sv | 123 ++++++++++++
 tb/tb_apb4_mem_slave.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB4 scratch/config memory slave.
package apb_mem_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_ACCESS} apb_state_t;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // Word-index width that stays at least one bit wide for tiny memories.
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_strb_ram.sv
// Word-organised register-file memory with per-byte write enables,
// synchronous clear and a combinational read port.
module apb_strb_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (strb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory slave: FSM, wait-state counter, address/error decode and outputs.
// Optional privilege checking via PPROT is enabled with `APB_SLV_PPROT_EN.
module apb4_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = MEM_DEPTH
`ifdef APB_SLV_PPROT_EN
  , parameter int PRIV_BASE = MEM_DEPTH/2
`endif
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`ifdef APB_SLV_PPROT_EN
  input  logic [2:0]              PPROT,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int STRB_W = DATA_WIDTH/8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = idx_width(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(STRB_W-1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RO_A     = ADDR_WIDTH'(RO_BASE);

  apb_state_t state, next_state;
  logic [3:0] cnt;
  logic err_q, write_q, commit;
  logic [IDX_W-1:0] idx_q;
  logic [DATA_WIDTH-1:0] rd_q, ram_rdata;

  logic [ADDR_WIDTH-1:0] word;
  logic [IDX_W-1:0] idx;
  logic misaligned, out_of_range, ro_err, priv_err, setup_err, setup;

  // Upper PADDR bits survive the shift, so any of them set lands out of range.
  assign word         = PADDR >> OFF_W;
  assign idx          = word[IDX_W-1:0];
  assign misaligned   = |(PADDR & OFF_MASK);
  assign out_of_range = (word >= DEPTH_A);
  assign ro_err       = PWRITE && (word >= RO_A);
`ifdef APB_SLV_PPROT_EN
  localparam logic [ADDR_WIDTH-1:0] PRIV_A = ADDR_WIDTH'(PRIV_BASE);
  assign priv_err     = (word >= PRIV_A) && !PPROT[0];
`else
  assign priv_err     = 1'b0;
`endif
  assign setup_err    = misaligned | out_of_range | ro_err | priv_err;
  assign setup        = (state == ST_IDLE) && PSEL && !PENABLE;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      ST_IDLE:   if (PSEL && !PENABLE) next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (!PSEL) begin
          next_state = ST_IDLE;
        end else if (cnt == 4'd0 && PENABLE) begin
          next_state = ST_IDLE;
          commit     = write_q && (err_q == RESP_OKAY);
        end
      end
      default:   next_state = ST_IDLE;
    endcase
  end

  // Error and read data are captured at the setup edge so PREADY/PSLVERR/PRDATA come from flops only.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt     <= 4'd0;
      err_q   <= RESP_OKAY;
      write_q <= 1'b0;
      idx_q   <= '0;
      rd_q    <= '0;
    end else if (setup) begin
      cnt     <= 4'(WAIT_STATES);
      err_q   <= setup_err ? RESP_SLVERR : RESP_OKAY;
      write_q <= PWRITE;
      idx_q   <= idx;
      rd_q    <= setup_err ? '0 : ram_rdata;
    end else if (state == ST_ACCESS && PSEL && cnt != 4'd0) begin
      cnt     <= cnt - 4'd1;
    end
  end

  apb_strb_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (PCLK),
    .reset (PRESET),
    .we    (commit),
    .strb  (PSTRB),
    .waddr (idx_q),
    .wdata (PWDATA),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  assign PREADY  = (state == ST_ACCESS) && (cnt == 4'd0);
  assign PSLVERR = PREADY ? err_q : RESP_OKAY;
  assign PRDATA  = PREADY ? rd_q : '0;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: three instances cover WAIT_STATES 0/3/2;
// instance 0 also uses RO_BASE=128 (and PPROT when `APB_SLV_PPROT_EN is defined).
module tb_apb4_mem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [15:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
`ifdef APB_SLV_PPROT_EN
  logic [2:0]  pprot   [3];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb4_mem_slave #(.WAIT_STATES(0), .RO_BASE(128)) u0 (
    .PCLK(clk), .PRESET(reset), .PSEL(psel[0]), .PENABLE(penable[0]), .PADDR(paddr[0]),
    .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
`ifdef APB_SLV_PPROT_EN
    .PPROT(pprot[0]),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb4_mem_slave #(.WAIT_STATES(3)) u3 (
    .PCLK(clk), .PRESET(reset), .PSEL(psel[1]), .PENABLE(penable[1]), .PADDR(paddr[1]),
    .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
`ifdef APB_SLV_PPROT_EN
    .PPROT(pprot[1]),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb4_mem_slave #(.WAIT_STATES(2)) u2 (
    .PCLK(clk), .PRESET(reset), .PSEL(psel[2]), .PENABLE(penable[2]), .PADDR(paddr[2]),
    .PWRITE(pwrite[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
`ifdef APB_SLV_PPROT_EN
    .PPROT(pprot[2]),
`endif
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer; waits = ACCESS cycles seen with PREADY low before completion.
  task automatic apb(input int k, input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic err, output int waits);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
    paddr[k] = addr; pwdata[k] = wd; pstrb[k] = st;
    tick();
    penable[k] = 1'b1;
    waits = -1; rd = '0; err = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (pready[k]) begin
        waits = n; rd = prdata[k]; err = pslverr[k];
        break;
      end
      tick();
    end
    if (waits < 0) begin
      checks++; failures++;
      $display("[TB] FAIL timeout inst=%0d addr=%h got no PREADY expected PREADY within 20 cycles", k, addr);
    end else begin
      tick();
    end
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int w;
    apb(0, 1'b1, 16'h0000, 32'h12345678, 4'hF, rd, err, w);
    reset = 1'b1; psel[0] = 1'b1; penable[0] = 1'b0;
    tick(); tick();
    checks++; if (pready[0] !== 1'b0) begin failures++; $display("[TB] FAIL reset_pready got=%b expected=0", pready[0]); end
    checks++; if (pslverr[0] !== 1'b0) begin failures++; $display("[TB] FAIL reset_pslverr got=%b expected=0", pslverr[0]); end
    checks++; if (prdata[0] !== 32'h0) begin failures++; $display("[TB] FAIL reset_prdata got=%h expected=0", prdata[0]); end
    reset = 1'b0; psel[0] = 1'b0;
    tick();
    apb(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_cleared got=%h expected=0", rd); end
  endtask

  task automatic test_wait0();
    logic [31:0] rd; logic err; int w;
    apb(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, rd, err, w);
    checks++; if (w !== 0) begin failures++; $display("[TB] FAIL wait0_write_waits got=%0d expected=0", w); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL wait0_write_err got=%b expected=0", err); end
    apb(0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, err, w);
    checks++; if (w !== 0) begin failures++; $display("[TB] FAIL wait0_read_waits got=%0d expected=0", w); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wait0_read_data got=%h expected=deadbeef", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL wait0_read_err got=%b expected=0", err); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err; int w;
    apb(0, 1'b1, 16'h0020, 32'h11223344, 4'hF, rd, err, w);
    apb(0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, rd, err, w);
    apb(0, 1'b0, 16'h0020, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("[TB] FAIL strobe_merge got=%h expected=11bb33dd", rd); end
    apb(0, 1'b1, 16'h0020, 32'hFFFFFFFF, 4'b0000, rd, err, w);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL strobe_zero_err got=%b expected=0", err); end
    apb(0, 1'b0, 16'h0020, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("[TB] FAIL strobe_zero_noop got=%h expected=11bb33dd", rd); end
  endtask

  task automatic test_wait3();
    logic [31:0] rd; logic err; int w;
    apb(1, 1'b0, 16'h0004, 32'h0, 4'h0, rd, err, w);
    checks++; if (w !== 3) begin failures++; $display("[TB] FAIL wait3_read_waits got=%0d expected=3", w); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("[TB] FAIL wait3_read_resp got=%h/%b expected=0/0", rd, err); end
    checks++; if (pready[1] !== 1'b0) begin failures++; $display("[TB] FAIL wait3_single_pulse got=%b expected=0", pready[1]); end
    apb(1, 1'b1, 16'h0004, 32'hCAFEF00D, 4'hF, rd, err, w);
    checks++; if (w !== 3) begin failures++; $display("[TB] FAIL wait3_write_waits got=%0d expected=3", w); end
    apb(1, 1'b0, 16'h0004, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL wait3_readback got=%h expected=cafef00d", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int w;
    apb(0, 1'b1, 16'h0402, 32'h55555555, 4'hF, rd, err, w);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL err_misaligned got=%b/%h expected=1/0", err, rd); end
    apb(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL err_misaligned_nowrite got=%h expected=0", rd); end
    apb(0, 1'b1, 16'h0012, 32'h55555555, 4'hF, rd, err, w);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_misaligned_inrange got=%b expected=1", err); end
    apb(0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL err_misaligned_unchanged got=%h expected=deadbeef", rd); end
    apb(0, 1'b0, 16'h0400, 32'h0, 4'h0, rd, err, w);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL err_out_of_range got=%b/%h expected=1/0", err, rd); end
    apb(0, 1'b0, 16'h03FC, 32'h0, 4'h0, rd, err, w);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL last_word_ok got=%b expected=0", err); end
    apb(0, 1'b1, 16'h0320, 32'h77777777, 4'hF, rd, err, w);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL err_read_only got=%b/%h expected=1/0", err, rd); end
    apb(0, 1'b0, 16'h0320, 32'h0, 4'h0, rd, err, w);
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin failures++; $display("[TB] FAIL ro_unchanged got=%b/%h expected=0/0", err, rd); end
    apb(0, 1'b1, 16'h0200, 32'h77777777, 4'hF, rd, err, w);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL ro_boundary_128 got=%b expected=1", err); end
    apb(0, 1'b1, 16'h01FC, 32'h13579BDF, 4'hF, rd, err, w);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rw_boundary_127 got=%b expected=0", err); end
    apb(0, 1'b0, 16'h01FC, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'h13579BDF) begin failures++; $display("[TB] FAIL rw_boundary_readback got=%h expected=13579bdf", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int w; int pulses;
    apb(2, 1'b1, 16'h0008, 32'h01020304, 4'hF, rd, err, w);
    checks++; if (w !== 2) begin failures++; $display("[TB] FAIL abort_pre_waits got=%0d expected=2", w); end
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 16'h0008; pwdata[2] = 32'hFFFFFFFF; pstrb[2] = 4'hF;
    tick();
    penable[2] = 1'b1;
    pulses = 0;
    if (pready[2]) pulses++;
    tick();
    if (pready[2]) pulses++;
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pready[2]) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("[TB] FAIL abort_no_pready got=%0d pulses expected=0", pulses); end
    apb(2, 1'b0, 16'h0008, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'h01020304) begin failures++; $display("[TB] FAIL abort_no_write got=%h expected=01020304", rd); end
    checks++; if (w !== 2 || err !== 1'b0) begin failures++; $display("[TB] FAIL abort_recover got=%0d/%b expected=2/0", w, err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w;
    apb(0, 1'b1, 16'h0030, 32'h0BADF00D, 4'hF, rd, err, w);
    checks++; if (pready[0] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_gap got=%b expected=0", pready[0]); end
    apb(0, 1'b0, 16'h0030, 32'h0, 4'h0, rd, err, w);
    checks++; if (rd !== 32'h0BADF00D || w !== 0) begin failures++; $display("[TB] FAIL b2b_read got=%h/%0d expected=0badf00d/0", rd, w); end
  endtask

`ifdef APB_SLV_PPROT_EN
  task automatic test_pprot();
    logic [31:0] rd; logic err; int w;
    pprot[0] = 3'b000;
    apb(0, 1'b0, 16'h0320, 32'h0, 4'h0, rd, err, w);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL pprot_unpriv got=%b expected=1", err); end
    pprot[0] = 3'b001;
    apb(0, 1'b0, 16'h0320, 32'h0, 4'h0, rd, err, w);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL pprot_priv got=%b expected=0", err); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
`ifdef APB_SLV_PPROT_EN
      pprot[k] = 3'b001;
`endif
    end
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_wait0();
    test_strobes();
    test_wait3();
    test_errors();
    test_abort();
    test_back_to_back();
`ifdef APB_SLV_PPROT_EN
    test_pprot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
